wb_obi_bridge: RTL
==================

Name: wb_obi_bridge

Overview:
Wishbone-classic responder that forwards each Wishbone transfer as one OBI initiator transaction. Lets Smartwave-side Wishbone masters (e.g. a debug or sequencer master) reach SoC memory and peripherals on the OBI bus. It is the reverse direction of the OBI-to-WB bridge.
One transfer is in flight at a time. The block translates the address window and returns read data and ack to Wishbone.

Parameters:
ADDR_W, 32, address width on both interfaces
DATA_W, 32, data width; byte-enable width is DATA_W/8
WIN_W, 16, number of low WB address bits passed through to OBI
OBI_BASE, 32'h0010_0000, OBI address base; bits [ADDR_W-1:WIN_W] replace WB upper bits
TIMEOUT_CYCLES, 256, timeout limit in cycles; used only with the optional feature

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
wb_cyc_i  in  1  WB cycle
wb_stb_i  in  1  WB strobe
wb_wr_en_i  in  1  WB write enable
wb_addr_i  in  ADDR_W  WB address
wb_wdata_i  in  DATA_W  WB write data
wb_byte_en_i  in  DATA_W/8  WB byte enables
wb_rdata_o  out  DATA_W  read data to WB master
wb_ack_o  out  1  transfer acknowledge, one-cycle pulse
wb_err_o  out  1  error termination, tied 0 unless the optional feature is enabled
obi_req_o  out  1  OBI request
obi_gnt_i  in  1  OBI grant
obi_addr_o  out  ADDR_W  OBI address
obi_wr_en_o  out  1  OBI write enable
obi_byte_en_o  out  DATA_W/8  OBI byte enables
obi_wdata_o  out  DATA_W  OBI write data
obi_rvalid_i  in  1  OBI response valid
obi_rdata_i  in  DATA_W  OBI read data

Behaviour:
- Reset (async, rst_i=1): state=IDLE. All outputs and internal registers 0: obi_req_o, obi_addr_o, obi_wr_en_o, obi_byte_en_o, obi_wdata_o, wb_ack_o, wb_err_o, wb_rdata_o.
- Reset asserted mid-transaction: abandon immediately, no ack. The OBI side may still return rvalid after reset; it is ignored in IDLE.
- FSM IDLE -> REQ -> RESP -> ACK -> IDLE.
- IDLE: when wb_cyc_i & wb_stb_i, register the transfer and go to REQ:
  - obi_addr_o = {OBI_BASE[ADDR_W-1:WIN_W], wb_addr_i[WIN_W-1:0]}
  - wb_wr_en_i, wb_byte_en_i and wb_wdata_i are captured into the OBI outputs.
- REQ: obi_req_o=1. Address, wr_en, byte_en and wdata are held stable until the grant (OBI rule).
  - On obi_gnt_i: req drops the next cycle; go to RESP.
  - Grant in the same cycle req rises is legal.
- RESP: wait for obi_rvalid_i (writes also receive rvalid). On rvalid:
  - reads: wb_rdata_o <= obi_rdata_i
  - writes: wb_rdata_o is left unchanged
  - go to ACK.
- ACK: wb_ack_o=1 for exactly one cycle, then IDLE.
- Because the return to IDLE is unconditional, a strobe still high in the ACK cycle is not double-issued. A back-to-back request is sampled in the following IDLE cycle.
- Minimum latency (gnt immediate, rvalid one cycle after gnt): ack 3 cycles after the stb sample edge. Throughput is one transfer per 4 cycles.
- wb_cyc_i dropped before ack (WB abort): the OBI transaction cannot be withdrawn after req is raised, so it completes normally. The ack is suppressed (an abort flag is set). wb_rdata_o is still updated.
- rvalid in REQ or IDLE (protocol violation): ignored.
- Byte enables are forwarded unchanged. There are no alignment checks.

Optional Feature:
Macro WB_OBI_TIMEOUT_EN.
- Enabled: a counter starts on entry to REQ and clears on entry to IDLE. If it reaches TIMEOUT_CYCLES-1 in REQ or RESP:
  - obi_req_o drops
  - wb_err_o pulses for one cycle instead of wb_ack_o
  - wb_rdata_o = 32'hDEAD_BEEF
  - the FSM returns to IDLE.
  - A later stray rvalid is ignored.
- Disabled: no counter is built, wb_err_o is tied 0, and the bridge waits indefinitely.

Decomposition:
- Package wb_obi_pkg holds:
  - state enum typedef (IDLE, REQ, RESP, ACK)
  - TIMEOUT_RDATA constant (32'hDEAD_BEEF)
  - default OBI_BASE constant.
- One sub-module, wb_obi_timeout: counter with start, clear and expire outputs. It is instantiated only under WB_OBI_TIMEOUT_EN.

Test Plan:
- Read, gnt immediate, rvalid next cycle, wb_addr=32'h0000_0040, obi_rdata=32'hCAFE_0001:
  - obi_addr_o=32'h0010_0040
  - wb_rdata_o=32'hCAFE_0001
  - wb_ack_o one cycle, 3 cycles after stb sample.
- Write, wdata=32'h1234_5678, byte_en=4'b0011, gnt delayed 5 cycles:
  - req, addr and wdata stable for all 6 REQ cycles
  - req drops after gnt
  - single ack after rvalid.
- WB abort: cyc dropped in RESP:
  - OBI transaction completes
  - no wb_ack_o
  - the next request in IDLE is processed normally.
- Back-to-back reads with stb held high through ack: exactly two OBI requests, two acks, correct data ordering.
- Reset asserted in RESP, then rvalid arrives after reset release: all outputs 0, no ack, FSM stays IDLE.
- With WB_OBI_TIMEOUT_EN and TIMEOUT_CYCLES=16, gnt never asserted:
  - wb_err_o pulses after 16 cycles
  - wb_rdata_o=32'hDEAD_BEEF
  - obi_req_o=0.

Source files
------------

// File: rtl/wb_obi_pkg.sv
// Shared types and constants for the Wishbone-to-OBI responder bridge.
package wb_obi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ACK  = 2'd3
  } state_e;

  localparam logic [31:0] TIMEOUT_RDATA    = 32'hDEAD_BEEF;
  localparam logic [31:0] OBI_BASE_DEFAULT = 32'h0010_0000;

endpackage

// File: rtl/wb_obi_timeout.sv
// Transaction watchdog: runs from start_i until clear_i, flags the last cycle.
module wb_obi_timeout #(
  parameter int CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      cnt_d = '0;
      run_d = 1'b1;
    end else if (clear_i) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (run_q && cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign expire_o = run_q && (cnt_q == LAST);

endmodule

// File: rtl/wb_obi_bridge.sv
// Wishbone-classic responder issuing one OBI initiator transfer per WB cycle.
// Optional watchdog with error termination: define WB_OBI_TIMEOUT_EN.
module wb_obi_bridge
  import wb_obi_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                WIN_W          = 16,
  parameter logic [ADDR_W-1:0] OBI_BASE       = ADDR_W'(OBI_BASE_DEFAULT),
  parameter int                TIMEOUT_CYCLES = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_wr_en_i,
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic [DATA_W-1:0]   wb_wdata_i,
  input  logic [DATA_W/8-1:0] wb_byte_en_i,
  output logic [DATA_W-1:0]   wb_rdata_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                obi_req_o,
  input  logic                obi_gnt_i,
  output logic [ADDR_W-1:0]   obi_addr_o,
  output logic                obi_wr_en_o,
  output logic [DATA_W/8-1:0] obi_byte_en_o,
  output logic [DATA_W-1:0]   obi_wdata_o,
  input  logic                obi_rvalid_i,
  input  logic [DATA_W-1:0]   obi_rdata_i
);

  localparam int BE_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                abort_q, abort_d;
  logic                err_q, err_d;
  logic                expire;
  logic                tmr_start;
  logic                tmr_clear;
  logic                unused_addr;

  assign unused_addr = ^wb_addr_i[ADDR_W-1:WIN_W];

`ifdef WB_OBI_TIMEOUT_EN
  wb_obi_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (tmr_start),
    .clear_i  (tmr_clear),
    .expire_o (expire)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  logic unused_tmr;
  assign unused_tmr = tmr_start ^ tmr_clear;
  assign expire     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    abort_d   = abort_q;
    err_d     = 1'b0;
    tmr_start = 1'b0;
    tmr_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        // err_q marks the error-termination cycle; hold off a new request
        if (wb_cyc_i && wb_stb_i && !err_q) begin
          addr_d    = {OBI_BASE[ADDR_W-1:WIN_W], wb_addr_i[WIN_W-1:0]};
          we_d      = wb_wr_en_i;
          be_d      = wb_byte_en_i;
          wdata_d   = wb_wdata_i;
          abort_d   = 1'b0;
          tmr_start = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (expire) begin
          err_d     = 1'b1;
          rdata_d   = DATA_W'(TIMEOUT_RDATA);
          tmr_clear = 1'b1;
          state_d   = IDLE;
        end else if (obi_gnt_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (expire) begin
          err_d     = 1'b1;
          rdata_d   = DATA_W'(TIMEOUT_RDATA);
          tmr_clear = 1'b1;
          state_d   = IDLE;
        end else if (obi_rvalid_i) begin
          if (!we_q) rdata_d = obi_rdata_i;
          state_d = ACK;
        end
      end
      ACK: begin
        tmr_clear = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign obi_req_o     = (state_q == REQ);
  assign obi_addr_o    = addr_q;
  assign obi_wr_en_o   = we_q;
  assign obi_byte_en_o = be_q;
  assign obi_wdata_o   = wdata_q;
  assign wb_rdata_o    = rdata_q;
  assign wb_ack_o      = (state_q == ACK) && !abort_q;
  assign wb_err_o      = err_q;

endmodule
